// File: rtl/mem_bank_cfg_pkg.sv
// Shared types and helpers for the memory-bank configuration sequencer.
// Holds the sequencer state encoding and the phase-counter width calculation.
package mem_bank_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Smallest width that can hold max(s, p, h).
    function automatic int cnt_width(input int s, input int p, input int h);
        int m;
        int w;
        m = (s > p) ? s : p;
        m = (m > h) ? m : h;
        w = 1;
        while ((1 << w) < (m + 1)) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_bank_wl_decoder.sv
// Registered binary-to-one-hot word-line decoder with enable.
// The output register guarantees wl never glitches from input changes.
module mem_bank_wl_decoder #(
    parameter int NUM_WL = 4,
    parameter int ADDR_W = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NUM_WL-1:0] wl
);

    logic [NUM_WL-1:0] onehot;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_WL; i++) begin
            onehot[i] = en && (addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            wl <= '0;
        end else begin
            wl <= onehot;
        end
    end

endmodule

// File: rtl/mem_bank_cfg_ctrl.sv
// Programs bank configuration cells through shared bl/wl nets, one frame per row:
// drive bl, pulse one word line, release, with programmable setup/pulse/hold timing.
module mem_bank_cfg_ctrl
    import mem_bank_cfg_pkg::*;
#(
    parameter int NUM_BL    = 4,
    parameter int NUM_WL    = 4,
    parameter int ADDR_W    = $clog2(NUM_WL),
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_wl_addr,
    input  logic [NUM_BL-1:0] cfg_bl_data,
    input  logic              cfg_last,
    input  logic              abort,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                CNT_W     = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0]  SETUP_END = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_END = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_END  = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0]   WL_LIMIT  = (ADDR_W + 1)'(NUM_WL);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [NUM_BL-1:0] data_q, bl_next;
    logic              last_q, ready_q;
    logic              hs, addr_ok, phase_end, done_next, wl_en;

    // abort in IDLE withdraws ready in the same cycle so the loader never sees a false accept.
    assign cfg_ready = ready_q & ~abort;
    assign hs        = cfg_valid & cfg_ready;
    assign addr_ok   = {1'b0, cfg_wl_addr} < WL_LIMIT;
    assign wl_en     = (next_state == PULSE);

    always_comb begin
        next_state = state;
        phase_end  = 1'b0;
        done_next  = 1'b0;
        bl_next    = '0;
        case (state)
            IDLE: begin
                if (hs && addr_ok) next_state = SETUP;
            end
            SETUP: begin
                phase_end = (cnt == SETUP_END);
                if (abort)          next_state = IDLE;
                else if (phase_end) next_state = PULSE;
            end
            PULSE: begin
                phase_end = (cnt == PULSE_END);
                if (abort)          next_state = IDLE;
                else if (phase_end) next_state = HOLD;
            end
            HOLD: begin
                phase_end = (cnt == HOLD_END);
                if (abort || phase_end) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        done_next = (state == HOLD && phase_end && !abort && last_q) ||
                    (hs && !addr_ok && cfg_last);

        if (next_state == IDLE)  bl_next = '0;
        else if (state == IDLE)  bl_next = cfg_bl_data;
        else                     bl_next = data_q;
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bl      <= '0;
        end else begin
            state   <= next_state;
            cnt     <= (next_state != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
            if (hs) begin
                addr_q <= cfg_wl_addr;
                data_q <= cfg_bl_data;
                last_q <= cfg_last;
            end
            ready_q <= (next_state == IDLE);
            busy    <= (next_state != IDLE);
            done    <= done_next;
            bl      <= bl_next;
            if (hs && !addr_ok) err <= 1'b1;
        end
    end

    mem_bank_wl_decoder #(
        .NUM_WL (NUM_WL),
        .ADDR_W (ADDR_W)
    ) u_wl_dec (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .en           (wl_en),
        .addr         (addr_q),
        .wl           (wl)
    );

endmodule

// File: tb/tb_mem_bank_cfg_ctrl.sv
// Directed bench for mem_bank_cfg_ctrl: default timing instance with a widened
// address bus, plus a second instance with stretched 3/4/2 phase timing.
module tb_mem_bank_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, abort, last, ready, busy, done, err;
    logic [2:0] addr;
    logic [3:0] data, bl, wl;
    logic       valid2, abort2, last2, ready2, busy2, done2, err2;
    logic [1:0] addr2;
    logic [3:0] data2, bl2, wl2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] wl_tr [0:15];
    logic [3:0] bl_tr [0:15];
    logic       rdy_tr [0:15];
    logic       done_tr [0:15];
    logic       busy_tr [0:15];
    logic       err_tr [0:15];
    int wl_first, wl_cnt, bl_cnt, rdy_first, done_cnt, done_first, busy_cnt;
    int onehot_bad, walk_bad, rdy_hits;
    logic [3:0] exp_wl;

    always #5 clk = ~clk;

    mem_bank_cfg_ctrl #(
        .NUM_BL(4), .NUM_WL(4), .ADDR_W(3)
    ) u_dut (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg_valid(valid), .cfg_ready(ready),
        .cfg_wl_addr(addr), .cfg_bl_data(data), .cfg_last(last), .abort(abort),
        .bl(bl), .wl(wl), .busy(busy), .done(done), .err(err)
    );

    mem_bank_cfg_ctrl #(
        .NUM_BL(4), .NUM_WL(4), .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)
    ) u_dut_t (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg_valid(valid2), .cfg_ready(ready2),
        .cfg_wl_addr(addr2), .cfg_bl_data(data2), .cfg_last(last2), .abort(abort2),
        .bl(bl2), .wl(wl2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the selected instance idle; records n samples after the handshake edge.
    task automatic frame(input bit sel, input logic [2:0] a, input logic [3:0] d,
                         input logic l, input int n);
        if (sel) begin
            valid2 = 1'b1; addr2 = a[1:0]; data2 = d; last2 = l;
        end else begin
            valid = 1'b1; addr = a; data = d; last = l;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            valid  = 1'b0;
            valid2 = 1'b0;
            wl_tr[k]   = sel ? wl2    : wl;
            bl_tr[k]   = sel ? bl2    : bl;
            rdy_tr[k]  = sel ? ready2 : ready;
            done_tr[k] = sel ? done2  : done;
            busy_tr[k] = sel ? busy2  : busy;
            err_tr[k]  = sel ? err2   : err;
        end
    endtask

    task automatic summarize(input int n);
        wl_first = 0; wl_cnt = 0; bl_cnt = 0; rdy_first = 0;
        done_cnt = 0; done_first = 0; busy_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            if (wl_tr[k] != 4'd0) begin
                wl_cnt++;
                if (wl_first == 0) wl_first = k;
            end
            if (bl_tr[k] != 4'd0) bl_cnt++;
            if (rdy_tr[k] && rdy_first == 0) rdy_first = k;
            if (done_tr[k]) begin
                done_cnt++;
                if (done_first == 0) done_first = k;
            end
            if (busy_tr[k]) busy_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0; abort = 1'b0; last = 1'b0; addr = '0; data = '0;
        valid2 = 1'b0; abort2 = 1'b0; last2 = 1'b0; addr2 = '0; data2 = '0;

        #12;
        check("reset_outs", {ready, busy, done, err, wl, bl}, 12'h000);
        check("reset_outs2", {ready2, busy2, done2, err2, wl2, bl2}, 12'h000);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {ready, busy}, 2'b10);

        // single frame, default 1/2/1 timing
        frame(1'b0, 3'd2, 4'b1010, 1'b1, 7);
        summarize(7);
        check("t1_wl_first", wl_first, 2);
        check("t1_wl_val", wl_tr[2], 4'b0100);
        check("t1_wl_len", wl_cnt, 2);
        check("t1_bl_val", bl_tr[1], 4'b1010);
        check("t1_bl_len", bl_cnt, 4);
        check("t1_ready_back", rdy_first, 5);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_at", done_first, 5);

        // four back-to-back frames with valid held high
        valid = 1'b1; addr = 3'd0; data = 4'h3; last = 1'b0;
        onehot_bad = 0; walk_bad = 0; rdy_hits = 0; done_cnt = 0; done_first = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if ($countones(wl) > 1) onehot_bad++;
            if (done) begin
                done_cnt++;
                done_first = k;
            end
            if (ready && k < 20) rdy_hits++;
            exp_wl = (k < 20 && (k % 5 == 2 || k % 5 == 3)) ? 4'(1 << (k / 5)) : 4'd0;
            if (wl !== exp_wl) walk_bad++;
            if (k % 5 == 0 && k < 20) begin
                addr = 3'(k / 5);
                last = (k / 5 == 3);
            end
            if (k == 20) valid = 1'b0;
        end
        check("t2_onehot", onehot_bad, 0);
        check("t2_wl_walk", walk_bad, 0);
        check("t2_ready_spacing", rdy_hits, 3);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_done_at", done_first, 20);

        // out-of-range address
        frame(1'b0, 3'd5, 4'hF, 1'b0, 2);
        check("t3_err", err_tr[1], 1'b1);
        check("t3_wl_quiet", wl_tr[1] | wl_tr[2], 4'd0);
        check("t3_ready", rdy_tr[1], 1'b1);
        check("t3_busy", busy_tr[1], 1'b0);
        check("t3_no_done", done_tr[1], 1'b0);
        frame(1'b0, 3'd7, 4'hF, 1'b1, 2);
        check("t3_done_last", {done_tr[1], done_tr[2]}, 2'b10);
        frame(1'b0, 3'd1, 4'b0110, 1'b1, 7);
        summarize(7);
        check("t3_recover_wl", wl_tr[2], 4'b0010);
        check("t3_recover_len", wl_cnt, 2);
        check("t3_recover_done", done_first, 5);
        check("t3_err_sticky", err_tr[7], 1'b1);

        // abort on the first PULSE cycle
        valid = 1'b1; addr = 3'd3; data = 4'h5; last = 1'b1;
        @(negedge clk); valid = 1'b0;
        check("t4_setup_busy", busy, 1'b1);
        @(negedge clk);
        check("t4_pulse_wl", wl, 4'b1000);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        check("t4_abort_outs", {wl, bl, busy, done, ready}, 11'b0000_0000_0_0_1);
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("t4_no_done", done_cnt, 0);
        valid = 1'b1; abort = 1'b1; addr = 3'd2; data = 4'h9; last = 1'b0; #1;
        check("t4_idle_abort_ready", ready, 1'b0);
        @(negedge clk);
        check("t4_idle_abort_nohs", busy, 1'b0);
        valid = 1'b0; abort = 1'b0;

        // asynchronous reset in the middle of PULSE
        frame(1'b0, 3'd0, 4'hF, 1'b0, 2);
        check("t5_pulse_wl", wl_tr[2], 4'b0001);
        #2 rst_n = 1'b0; #1;
        check("t5_async_clear", {wl, bl, busy}, 9'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("t5_after_release", {ready, err}, 2'b10);

        // stretched 3/4/2 timing instance
        check("t6_ready_pre", ready2, 1'b1);
        frame(1'b1, 3'd1, 4'b1100, 1'b1, 12);
        summarize(12);
        check("t6_setup_len", wl_first, 4);
        check("t6_wl_val", wl_tr[4], 4'b0010);
        check("t6_pulse_len", wl_cnt, 4);
        check("t6_bl_len", bl_cnt, 9);
        check("t6_busy_len", busy_cnt, 9);
        check("t6_ready_back", rdy_first, 10);
        check("t6_done_at", done_first, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
